// File: rtl/sysid_pkg.sv
// Shared state encoding, slave word addresses and default expected values for the sysid checker.
// Definitions only; no timing or flow-control behaviour of its own.
package sysid_pkg;

  typedef enum logic [1:0] {IDLE, RD_ID, RD_TS, DONE} sysid_state_t;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  localparam logic [31:0] SYSID_EXPECTED_ID = 32'd0;
  localparam logic [31:0] SYSID_EXPECTED_TS = 32'd1390424643;

endpackage

// File: rtl/sysid_read_timer.sv
// Per-read stall timer: counts waitrequest cycles and flags expiry combinationally at the limit.
// No latency beyond the count register; TIMEOUT_CYCLES=0 disables expiry entirely.
module sysid_read_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic stall,
  output logic expired
);

  localparam int W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [W-1:0] LIMIT = W'(TIMEOUT_CYCLES);

  logic [W-1:0] count;

  // Saturates at the limit so a disabled or long-expired timer never wraps.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (stall && count != LIMIT) begin
      count <= count + W'(1);
    end
  end

  assign expired = (TIMEOUT_CYCLES != 0) && stall && (count == LIMIT);

endmodule

// File: rtl/sysid_checker.sv
// Boot-gate checker: reads sysid ID (addr 0) and timestamp (addr 1), compares with expected values.
// 3 cycles start-to-done without stalls; holds each read through waitrequest, aborts at TIMEOUT_CYCLES.
module sysid_checker
  import sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = SYSID_EXPECTED_ID,
  parameter logic [31:0] EXPECTED_TS    = SYSID_EXPECTED_TS,
  parameter int unsigned TIMEOUT_CYCLES = 1023,
  parameter bit          AUTO_START     = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  sysid_state_t state;
  logic         auto_pend;
  logic         accept;
  logic         stall;
  logic         expired;
  logic         launch;

  assign accept = avm_read & ~avm_waitrequest;
  assign stall  = avm_read & avm_waitrequest;
  assign launch = ((state == IDLE) && (start || auto_pend)) || ((state == DONE) && start);

  // Every state transition restarts the timer.
  sysid_read_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clock  (clock),
    .reset  (reset),
    .clear  (accept | expired | launch),
    .stall  (stall),
    .expired(expired)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      auto_pend   <= AUTO_START;
      avm_address <= SYSID_ADDR_ID;
      avm_read    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      id_ok       <= 1'b0;
      ts_ok       <= 1'b0;
      timeout     <= 1'b0;
      id_value    <= '0;
      ts_value    <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (launch) begin
            state       <= RD_ID;
            auto_pend   <= 1'b0;
            avm_address <= SYSID_ADDR_ID;
            avm_read    <= 1'b1;
            busy        <= 1'b1;
            done        <= 1'b0;
            id_ok       <= 1'b0;
            ts_ok       <= 1'b0;
            timeout     <= 1'b0;
          end
        end
        RD_ID: begin
          if (accept) begin
            id_value    <= avm_readdata;
            state       <= RD_TS;
            avm_address <= SYSID_ADDR_TS;
          end else if (expired) begin
            state    <= DONE;
            avm_read <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b1;
            timeout  <= 1'b1;
          end
        end
        RD_TS: begin
          // Acceptance takes priority; expiry only fires while still stalled.
          if (accept) begin
            ts_value <= avm_readdata;
            state    <= DONE;
            avm_read <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b1;
            id_ok    <= (id_value == EXPECTED_ID);
            ts_ok    <= (avm_readdata == EXPECTED_TS);
          end else if (expired) begin
            state    <= DONE;
            avm_read <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b1;
            timeout  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sysid_checker.sv
// Self-checking bench for sysid_checker: vector table, hand-written corner sequences and
// randomized checks against an outcome model; a reactive slave supplies waitrequest and data.
module tb_sysid_checker;

  localparam int          TO_CYC = 8;
  localparam logic [31:0] EXP_ID = 32'd0;
  localparam logic [31:0] EXP_TS = 32'd1390424643;

  logic        clock;
  logic        reset;
  logic        start;
  logic        avm_address;
  logic        avm_read;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;
  logic        busy, done, id_ok, ts_ok, timeout;
  logic [31:0] id_value, ts_value;

  sysid_checker #(
    .EXPECTED_ID   (EXP_ID),
    .EXPECTED_TS   (EXP_TS),
    .TIMEOUT_CYCLES(TO_CYC),
    .AUTO_START    (1'b1)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .start          (start),
    .avm_address    (avm_address),
    .avm_read       (avm_read),
    .avm_readdata   (avm_readdata),
    .avm_waitrequest(avm_waitrequest),
    .busy           (busy),
    .done           (done),
    .id_ok          (id_ok),
    .ts_ok          (ts_ok),
    .timeout        (timeout),
    .id_value       (id_value),
    .ts_value       (ts_value)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int n_run  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  // Slave behaviour, set by the test sequences.
  logic [31:0] id_word, ts_word;
  int          stall_id, stall_ts;
  // Slave bookkeeping and protocol observations.
  int   wcnt      = 0;
  int   drops     = 0;
  int   addr_err  = 0;
  logic prev_read = 1'b0;
  logic prev_addr = 1'b0;
  logic prev_wait = 1'b0;

  initial begin
    avm_waitrequest = 1'b0;
    avm_readdata    = 32'hDEAD_BEEF;
    forever begin
      @(negedge clock);
      if (prev_read && prev_wait) begin
        if (!avm_read) drops++;
        else if (avm_address != prev_addr) addr_err++;
      end
      if (avm_read && (!prev_read || avm_address != prev_addr)) wcnt = 0;
      if (avm_read) begin
        avm_waitrequest = (wcnt < (avm_address ? stall_ts : stall_id));
        avm_readdata    = avm_waitrequest ? 32'hBAD0_0BAD : (avm_address ? ts_word : id_word);
        wcnt++;
      end else begin
        avm_waitrequest = 1'b0;
        avm_readdata    = 32'hDEAD_BEEF;
      end
      prev_read = avm_read;
      prev_addr = avm_address;
      prev_wait = avm_waitrequest;
    end
  end

  // Model of the captured words, updated from the outcome of each check.
  logic [31:0] m_id, m_ts;

  task automatic run_vec(input string nm, input logic [31:0] idw, input logic [31:0] tsw,
                         input int sid, input int sts, input bit e_idok, input bit e_tsok,
                         input bit e_to, input int e_lat);
    int lat;
    lat      = -1;
    id_word  = idw;
    ts_word  = tsw;
    stall_id = sid;
    stall_ts = sts;
    drops    = 0;
    addr_err = 0;
    @(negedge clock);
    start = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clock);
      if (c == 1) begin
        start = 1'b0;
        chk({nm, ".entry"}, 32'({busy, done, id_ok, ts_ok, timeout}), 32'b10000);
      end
      if (done) begin
        lat = c;
        break;
      end
    end
    if (sid <= TO_CYC) m_id = idw;
    if (!e_to) m_ts = tsw;
    chk({nm, ".lat"}, 32'(lat), 32'(e_lat));
    chk({nm, ".flags"}, 32'({id_ok, ts_ok, timeout, busy, avm_read}),
        32'({e_idok, e_tsok, e_to, 2'b00}));
    chk({nm, ".id_value"}, id_value, m_id);
    chk({nm, ".ts_value"}, ts_value, m_ts);
    chk({nm, ".drops"}, 32'(drops), 32'(e_to));
    chk({nm, ".addr_stable"}, 32'(addr_err), 32'd0);
  endtask

  typedef struct {
    logic [31:0] idw;
    logic [31:0] tsw;
    int          sid;
    int          sts;
    bit          idok;
    bit          tsok;
    bit          to;
    int          lat;
  } vec_t;

  vec_t tbl[9];
  int   first;
  int   late_busy;
  bit   found;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{EXP_ID,        EXP_TS,          0,   0, 1'b1, 1'b1, 1'b0, 3};
    tbl[1] = '{EXP_ID,        EXP_TS,          5,   0, 1'b1, 1'b1, 1'b0, 8};
    tbl[2] = '{EXP_ID,        32'd1390424644,  0,   0, 1'b1, 1'b0, 1'b0, 3};
    tbl[3] = '{32'd1,         EXP_TS,          0,   0, 1'b0, 1'b1, 1'b0, 3};
    tbl[4] = '{EXP_ID,        EXP_TS,          2,   3, 1'b1, 1'b1, 1'b0, 8};
    tbl[5] = '{EXP_ID,        EXP_TS,          8,   8, 1'b1, 1'b1, 1'b0, 19};
    tbl[6] = '{EXP_ID,        EXP_TS,          9,   0, 1'b0, 1'b0, 1'b1, 10};
    tbl[7] = '{32'h1234_5678, EXP_TS,          0,   9, 1'b0, 1'b0, 1'b1, 11};
    tbl[8] = '{EXP_ID,        EXP_TS,        100,   0, 1'b0, 1'b0, 1'b1, 10};

    reset    = 1'b1;
    start    = 1'b0;
    id_word  = EXP_ID;
    ts_word  = EXP_TS;
    stall_id = 0;
    stall_ts = 0;

    // Reset state, then the automatic check after release.
    repeat (3) @(negedge clock);
    chk("rst.ctrl", 32'({avm_read, avm_address, busy, done, id_ok, ts_ok, timeout}), 32'd0);
    chk("rst.id_value", id_value, 32'd0);
    chk("rst.ts_value", ts_value, 32'd0);
    reset = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clock);
      if (c == 2) chk("auto.c2_done", 32'(done), 32'd0);
    end
    chk("auto.flags", 32'({done, id_ok, ts_ok, busy, timeout}), 32'b11100);
    m_id = EXP_ID;
    m_ts = EXP_TS;
    chk("auto.ts_value", ts_value, m_ts);

    for (int i = 0; i < 9; i++) begin
      run_vec($sformatf("tbl%0d", i), tbl[i].idw, tbl[i].tsw, tbl[i].sid, tbl[i].sts,
              tbl[i].idok, tbl[i].tsok, tbl[i].to, tbl[i].lat);
    end

    // start pulsed while busy is ignored.
    id_word  = EXP_ID;
    ts_word  = EXP_TS;
    stall_id = 4;
    stall_ts = 0;
    first    = -1;
    @(negedge clock);
    start = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clock);
      start = (c == 2);
      if (done && first < 0) first = c;
    end
    chk("busy_start.lat", 32'(first), 32'd7);
    chk("busy_start.idle", 32'({done, busy, id_ok, ts_ok}), 32'b1011);

    // start coinciding with the final acceptance is ignored.
    stall_id  = 0;
    stall_ts  = 2;
    first     = -1;
    late_busy = 0;
    @(negedge clock);
    start = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clock);
      start = (c == 4);
      if (done && first < 0) first = c;
      if (c > 5 && busy) late_busy++;
    end
    chk("same_cycle.lat", 32'(first), 32'd5);
    chk("same_cycle.no_rerun", 32'(late_busy), 32'd0);
    chk("same_cycle.done", 32'({done, busy}), 32'b10);
    m_id = EXP_ID;
    m_ts = EXP_TS;

    // Randomized checks against the outcome model.
    for (int i = 0; i < 25; i++) begin
      logic [31:0] idw, tsw;
      int sid, sts, lat;
      bit to_id, to_ts, to;
      idw   = ($urandom_range(0, 3) == 0) ? 32'($urandom) : EXP_ID;
      tsw   = ($urandom_range(0, 3) == 0) ? 32'($urandom) : EXP_TS;
      sid   = $urandom_range(0, 10);
      sts   = $urandom_range(0, 10);
      to_id = (sid > TO_CYC);
      to_ts = !to_id && (sts > TO_CYC);
      to    = to_id || to_ts;
      lat   = to_id ? TO_CYC + 2 : (to_ts ? 3 + sid + TO_CYC : 3 + sid + sts);
      run_vec($sformatf("rnd%0d", i), idw, tsw, sid, sts,
              !to && (idw == EXP_ID), !to && (tsw == EXP_TS), to, lat);
    end

    // Reset during the timestamp read, then the automatic rerun.
    id_word  = EXP_ID;
    ts_word  = EXP_TS;
    stall_id = 0;
    stall_ts = 5;
    found    = 1'b0;
    @(negedge clock);
    start = 1'b1;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clock);
      start = 1'b0;
      if (avm_read && avm_address) found = 1'b1;
    end
    chk("rstmid.reach_ts", 32'(found), 32'd1);
    reset = 1'b1;
    #1;
    chk("rstmid.read_drop", 32'(avm_read), 32'd0);
    chk("rstmid.ctrl", 32'({avm_address, busy, done, id_ok, ts_ok, timeout}), 32'd0);
    chk("rstmid.ts_value", ts_value, 32'd0);
    chk("rstmid.id_value", id_value, 32'd0);
    stall_ts = 0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clock);
      if (c == 2) chk("rerun.c2_done", 32'(done), 32'd0);
    end
    chk("rerun.flags", 32'({done, id_ok, ts_ok, busy, timeout}), 32'b11100);
    chk("rerun.ts_value", ts_value, EXP_TS);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
